// File: rtl/game_controller.sv
// Frogger-style game sequencer: lives, level, death/win pauses.
// Ports: CLK, RST_N (sync, active-low); frame_tick, start, collision,
// at_goal in; game_state, lives, level, car_speed, move_en, player_rst out.
module game_controller #(
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 90
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       collision,
    input  logic       at_goal,
    output logic [2:0] game_state,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic [3:0] car_speed,
    output logic       move_en,
    output logic       player_rst
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PLAY     = 3'd1;
    localparam logic [2:0] S_DEATH    = 3'd2;
    localparam logic [2:0] S_LEVEL_UP = 3'd3;
    localparam logic [2:0] S_OVER     = 3'd4;

    logic [2:0] r_state;
    logic [1:0] r_lives;
    logic [2:0] r_level;
    logic [3:0] r_speed;
    logic [7:0] r_timer;
    logic       r_move_en;
    logic       r_player_rst;
    logic       r_start_q;

    logic       w_start_edge;
    logic       w_expire;
    logic       w_enter_play;
    logic [2:0] w_state_nxt;
    logic [1:0] w_lives_nxt;
    logic [2:0] w_level_nxt;
    logic [7:0] w_timer_nxt;

    always_comb begin
        w_start_edge = start & ~r_start_q;
        // <=1 so a corrupted zero timer still expires instead of hanging
        w_expire     = frame_tick && (r_timer <= 8'd1);
        w_state_nxt  = r_state;
        w_lives_nxt  = r_lives;
        w_level_nxt  = r_level;
        w_timer_nxt  = r_timer;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_PLAY;
                    w_lives_nxt = 2'(LIVES_INIT);
                    w_level_nxt = 3'd0;
                end
            end
            S_PLAY: begin
                // collision wins over reaching the goal
                if (collision) begin
                    w_state_nxt = S_DEATH;
                    w_lives_nxt = r_lives - 2'd1;
                    w_timer_nxt = 8'(DEATH_FRAMES);
                end else if (at_goal) begin
                    w_state_nxt = S_LEVEL_UP;
                    w_timer_nxt = 8'(WIN_FRAMES);
                end
            end
            S_DEATH: begin
                if (w_expire) begin
                    w_timer_nxt = 8'd0;
                    w_state_nxt = (r_lives == 2'd0) ? S_OVER : S_PLAY;
                end else if (frame_tick) begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            S_LEVEL_UP: begin
                if (w_expire) begin
                    w_timer_nxt = 8'd0;
                    w_state_nxt = S_PLAY;
                    w_level_nxt = (r_level == 3'd7) ? 3'd7
                                                    : r_level + 3'd1;
                end else if (frame_tick) begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            S_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_enter_play = (w_state_nxt == S_PLAY) && (r_state != S_PLAY);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_lives      <= 2'(LIVES_INIT);
            r_level      <= 3'd0;
            r_speed      <= 4'd8;
            r_timer      <= 8'd0;
            r_move_en    <= 1'b0;
            r_player_rst <= 1'b0;
            // a start held through reset must be released first
            r_start_q    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_lives      <= w_lives_nxt;
            r_level      <= w_level_nxt;
            r_speed      <= 4'd8 - {1'b0, w_level_nxt};
            r_timer      <= w_timer_nxt;
            r_player_rst <= w_enter_play;
            r_move_en    <= (w_state_nxt == S_PLAY) && !w_enter_play;
            r_start_q    <= start;
        end
    end

    assign game_state = r_state;
    assign lives      = r_lives;
    assign level      = r_level;
    assign car_speed  = r_speed;
    assign move_en    = r_move_en;
    assign player_rst = r_player_rst;

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have the parameter LIVES_INIT, default 3, giving the lives at game start (legal range 1..3).
REQ-002 The block SHALL have the parameter DEATH_FRAMES, default 60, giving the length of the death pause in frames (legal range 1..255).
REQ-003 The block SHALL have the parameter WIN_FRAMES, default 90, giving the length of the level-clear pause in frames (legal range 1..255).
REQ-004 The block SHALL have the port CLK, input, 1 bit: the 25 MHz system clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have the port frame_tick, input, 1 bit: one-cycle pulse, once per VGA frame.
REQ-007 The block SHALL have the port start, input, 1 bit: debounced start switch, level-sensitive.
REQ-008 The block SHALL have the port collision, input, 1 bit: player/car overlap, level-sensitive.
REQ-009 The block SHALL have the port at_goal, input, 1 bit: player has reached the goal row, level-sensitive.
REQ-010 The block SHALL have the port game_state, output, 3 bits, encoded IDLE=0, PLAY=1, DEATH=2, LEVEL_UP=3, GAME_OVER=4.
REQ-011 The block SHALL have the port lives, output, 2 bits: remaining lives.
REQ-012 The block SHALL have the port level, output, 3 bits: current level, 0..7.
REQ-013 The block SHALL have the port car_speed, output, 4 bits: frames per car step, equal to 8 - level.
REQ-014 The block SHALL have the port move_en, output, 1 bit: enables car and player movement.
REQ-015 The block SHALL have the port player_rst, output, 1 bit: one-cycle pulse that returns the player to the spawn position.

Function
REQ-016 All outputs SHALL be registered; the block SHALL have no combinational path from any input to any output.
REQ-017 start_edge SHALL equal start AND NOT start_q, where start_q is start registered by one cycle.
REQ-018 IDLE SHALL move to PLAY on start_edge, in the same update loading lives=LIVES_INIT and level=0.
REQ-019 In PLAY, collision=1 SHALL move the block to DEATH, decrement lives by 1, and load timer=DEATH_FRAMES.
REQ-020 In PLAY, at_goal=1 with collision=0 SHALL move the block to LEVEL_UP and load timer=WIN_FRAMES.
REQ-021 When collision and at_goal are both 1 in the same PLAY cycle, collision SHALL take priority and the block SHALL enter DEATH.
REQ-022 In DEATH and LEVEL_UP, the timer SHALL decrement only on cycles where frame_tick=1.
REQ-023 The pause SHALL expire on the frame_tick cycle where timer==1, so the pause lasts exactly N frame_ticks.
REQ-024 On DEATH expiry, the block SHALL go to GAME_OVER if lives==0, otherwise to PLAY.
REQ-025 On LEVEL_UP expiry, the block SHALL go to PLAY and set level=level+1, saturating at 7; lives SHALL be unchanged.
REQ-026 GAME_OVER SHALL move to IDLE on start_edge; lives and level SHALL hold their values until the next IDLE->PLAY transition.
REQ-027 collision and at_goal SHALL be ignored outside PLAY.
REQ-028 start SHALL be ignored in PLAY, DEATH and LEVEL_UP.
REQ-029 frame_tick SHALL be ignored in IDLE, PLAY and GAME_OVER.
REQ-030 player_rst SHALL be 1 for exactly one cycle: the first cycle in which game_state==PLAY after any entry into PLAY.
REQ-031 move_en SHALL be 1 exactly when game_state==PLAY, except in the player_rst cycle, where it is 0.
REQ-032 car_speed SHALL be updated in the same cycle as level.
REQ-033 car_speed SHALL never be 0; its range is 8..1.
REQ-034 The game_state encodings 5..7 SHALL be unreachable; if ever entered, the block SHALL go to IDLE on the next cycle.

Reset
REQ-035 On a clock edge with RST_N=0, the block SHALL set game_state=IDLE, lives=LIVES_INIT, level=0, car_speed=8, move_en=0, player_rst=0, timer=0 and start_q=1.
REQ-036 Reset SHALL take priority over every other event and SHALL abort any state or pause immediately.
REQ-037 start_q resetting to 1 SHALL prevent a start switch held through reset from starting a game; a release and re-press is required.

Verification
REQ-038 Reset, then a start pulse: game_state 0->1, player_rst high for 1 cycle, then move_en=1, lives=3, level=0, car_speed=8.
REQ-039 In PLAY, collision for 1 cycle: game_state=2, lives=2; 59 frame_ticks keep state 2; the 60th returns state 1 with a player_rst pulse.
REQ-040 Three collisions with DEATH_FRAMES elapsed each time: the third expiry gives game_state=4, lives=0; a start pulse gives 0; the next start gives 1 with lives=3.
REQ-041 collision and at_goal asserted in the same cycle: game_state=2, lives decrements, level unchanged.
REQ-042 Eight goal reaches, each followed by 90 frame_ticks: level saturates at 7 and car_speed holds at 1.
REQ-043 start held high during reset and after it: game stays IDLE; RST_N=0 mid-DEATH returns IDLE, lives=3 on the next cycle.
